// File: rtl/csa_pkg.sv
// csa_pkg: shared op encoding and default parameters for the pipelined carry-select adder
//   op_t       : OP_ADD / OP_SUB operation select
//   CSA_WIDTH  : default operand/result width
//   CSA_BLOCK  : default carry-select slice width
//   CSA_STAGES : default number of register stages
package csa_pkg;
    typedef enum logic {OP_ADD, OP_SUB} op_t;
    localparam int CSA_WIDTH  = 32;
    localparam int CSA_BLOCK  = 4;
    localparam int CSA_STAGES = 2;
endpackage

// File: rtl/csel_block.sv
// csel_block: one carry-select slice, both carry-in hypotheses computed in parallel
//   a, b   : slice operands (b already inverted for subtraction)
//   s0, c0 : sum and carry-out assuming carry-in = 0
//   s1, c1 : sum and carry-out assuming carry-in = 1
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] s0,
    output logic [BLOCK-1:0] s1,
    output logic             c0,
    output logic             c1
);
    assign {c0, s0} = {1'b0, a} + {1'b0, b};
    assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
endmodule

// File: rtl/pipelined_select_adder.sv
// pipelined_select_adder: STAGES-deep carry-select adder/subtractor with valid/ready flow control
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (A, B, cin, op)
//   out_valid, out_ready: result handshake (S, cout, ovf, zero)
module pipelined_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = CSA_WIDTH,
    parameter int BLOCK  = CSA_BLOCK,
    parameter int STAGES = CSA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int SPS  = NBLK / STAGES;
    localparam int L    = STAGES - 1;

    // st_* are the inputs seen by each stage's slices; nx_* what that stage hands on
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic [STAGES-1:0] st_c, nx_c, ld, v;
    logic [BLOCK-1:0]  s0 [NBLK-1:1];
    logic [BLOCK-1:0]  s1 [NBLK-1:1];
    logic [NBLK-1:1]   c0, c1;
    logic [NBLK-1:0]   cy;
    logic [WIDTH-1:0]  sum;
    logic              ci;

    // Subtraction is folded in up front: invert B and the borrow, then everything is addition
    assign st_a[0] = A;
    assign st_b[0] = (op == OP_SUB) ? ~B : B;
    assign st_c[0] = (op == OP_SUB) ? ~cin : cin;
    assign st_s[0] = '0;

    for (genvar j = 1; j < NBLK; j++) begin : g_blk
        csel_block #(.BLOCK(BLOCK)) u_blk (
            .a  (st_a[j/SPS][j*BLOCK +: BLOCK]),
            .b  (st_b[j/SPS][j*BLOCK +: BLOCK]),
            .s0 (s0[j]),
            .s1 (s1[j]),
            .c0 (c0[j]),
            .c1 (c1[j])
        );
    end

    // Slice 0 ripples on the real carry; other slices select, restarting from the
    // registered carry at each stage boundary
    always_comb begin
        sum = '0;
        cy  = '0;
        ci  = 1'b0;
        for (int j = 0; j < NBLK; j++) begin
            if (j == 0) begin
                {cy[0], sum[0 +: BLOCK]} = {1'b0, st_a[0][0 +: BLOCK]} + {1'b0, st_b[0][0 +: BLOCK]}
                                         + {{BLOCK{1'b0}}, st_c[0]};
            end else begin
                ci = (j % SPS == 0) ? st_c[j / SPS] : cy[j - 1];
                sum[j*BLOCK +: BLOCK] = ci ? s1[j] : s0[j];
                cy[j] = c0[j] | (c1[j] & ci);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx_s[k] = st_s[k];
            nx_s[k][k*SPS*BLOCK +: SPS*BLOCK] = sum[k*SPS*BLOCK +: SPS*BLOCK];
            nx_c[k] = cy[(k+1)*SPS-1];
        end
    end

    // Load enables ripple back from the output so empty stages always accept
    always_comb begin
        ld[L] = !v[L] || out_ready;
        for (int k = L - 1; k >= 0; k--) ld[k] = !v[k] || ld[k+1];
    end

    assign in_ready  = ld[0];
    assign out_valid = v[L];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v <= '0;
        else for (int k = 0; k < STAGES; k++) if (ld[k]) v[k] <= (k == 0) ? in_valid : v[(k == 0) ? 0 : k - 1];
    end

    // Intermediate stages carry the operands forward; consumed low bits are never read again
    for (genvar k = 0; k < L; k++) begin : g_stg
        logic [WIDTH-1:0] a, b, s;
        logic             c;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a <= '0;
                b <= '0;
                s <= '0;
                c <= 1'b0;
            end else if (ld[k]) begin
                a <= st_a[k];
                b <= st_b[k];
                s <= nx_s[k];
                c <= nx_c[k];
            end
        end
        assign st_a[k+1] = a;
        assign st_b[k+1] = b;
        assign st_s[k+1] = s;
        assign st_c[k+1] = c;
    end

    // Final stage registers the complete result and its flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (ld[L]) begin
            S    <= nx_s[L];
            cout <= nx_c[L];
            ovf  <= (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) && (nx_s[L][WIDTH-1] != st_a[L][WIDTH-1]);
            zero <= nx_s[L] == '0;
        end
    end
endmodule

// File: tb/tb_pipelined_select_adder.sv
// tb_pipelined_select_adder: directed and randomized checks of the pipelined carry-select adder
module tb_pipelined_select_adder;
    import csa_pkg::*;

    localparam int WS [4] = '{16, 32, 16, 32};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       iv, ordy, ci, ir, ov, co, of, zr;
    logic [3:0][31:0] a, b, s;
    op_t              opv [4];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    assign s[0][31:16] = '0;
    assign s[2][31:16] = '0;

    pipelined_select_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0][15:0]), .B(b[0][15:0]),
        .cin(ci[0]), .op(opv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .S(s[0][15:0]),
        .cout(co[0]), .ovf(of[0]), .zero(zr[0]));
    pipelined_select_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]),
        .cin(ci[1]), .op(opv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .S(s[1]),
        .cout(co[1]), .ovf(of[1]), .zero(zr[1]));
    pipelined_select_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2][15:0]), .B(b[2][15:0]),
        .cin(ci[2]), .op(opv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .S(s[2][15:0]),
        .cout(co[2]), .ovf(of[2]), .zero(zr[2]));
    pipelined_select_adder #(.WIDTH(32), .BLOCK(8), .STAGES(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .A(a[3]), .B(b[3]),
        .cin(ci[3]), .op(opv[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .S(s[3]),
        .cout(co[3]), .ovf(of[3]), .zero(zr[3]));

    task automatic put(input int g, input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input op_t o, input logic r);
        iv[g]   = v;
        a[g]    = x;
        b[g]    = y;
        ci[g]   = c;
        opv[g]  = o;
        ordy[g] = r;
    endtask

    task automatic test_reset;
        iv = '0; ordy = '1; a = '0; b = '0; ci = '0;
        for (int i = 0; i < 4; i++) opv[i] = OP_ADD;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov[0]); end
        checks++;
        if (s[0] !== 32'h0) begin errors++; $display("FAIL reset_S got %h exp 0", s[0]); end
        checks++;
        if ({co[0], of[0], zr[0]} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got cout=%b ovf=%b zero=%b exp 000", co[0], of[0], zr[0]);
        end
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir[0]); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ir[0], ov[0]} !== 2'b10) begin
            errors++; $display("FAIL post_reset got in_ready=%b out_valid=%b exp 1 0", ir[0], ov[0]);
        end
    endtask

    task automatic test_add_wrap;
        @(negedge clk);
        put(0, 1'b1, 32'hFFFF, 32'h0001, 1'b0, OP_ADD, 1'b1);
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL wrap_accept got in_ready=%b exp 1", ir[0]); end
        @(negedge clk);
        put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL wrap_early got out_valid=%b exp 0", ov[0]); end
        @(negedge clk);
        checks++;
        if ({ov[0], s[0][15:0], co[0], of[0], zr[0]} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_result got v=%b S=%h c=%b o=%b z=%b exp v=1 S=0000 c=1 o=0 z=1",
                     ov[0], s[0][15:0], co[0], of[0], zr[0]);
        end
    endtask

    task automatic test_arith;
        @(negedge clk);
        put(0, 1'b1, 32'h7FFF, 32'h0001, 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        put(0, 1'b1, 32'h0005, 32'h0007, 1'b0, OP_SUB, 1'b1);
        @(negedge clk);
        put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
        checks++;
        if ({ov[0], s[0][15:0], co[0], of[0], zr[0]} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf got v=%b S=%h c=%b o=%b z=%b exp v=1 S=8000 c=0 o=1 z=0",
                     ov[0], s[0][15:0], co[0], of[0], zr[0]);
        end
        @(negedge clk);
        checks++;
        if ({ov[0], s[0][15:0], co[0], of[0], zr[0]} !== {1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow got v=%b S=%h c=%b o=%b z=%b exp v=1 S=fffe c=0 o=0 z=0",
                     ov[0], s[0][15:0], co[0], of[0], zr[0]);
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0, recv = 0;
        logic held = 1'b0, saw_low = 1'b0, r;
        logic [31:0] hold_s = '0, e;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            r = !(c >= 3 && c <= 5);
            if (sent < 8) put(0, 1'b1, 32'(sent * 32'h1111), 32'h0101, 1'b0, OP_ADD, r);
            else put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, r);
            #1;
            if (ov[0] && !ordy[0]) begin
                if (held) begin
                    checks++;
                    if (s[0] !== hold_s) begin
                        errors++; $display("FAIL stall_stable got S=%h exp %h", s[0], hold_s);
                    end
                end
                held = 1'b1;
                hold_s = s[0];
            end else held = 1'b0;
            if (ov[0] && ordy[0]) begin
                e = 32'(recv * 32'h1111 + 32'h0101) & 32'hFFFF;
                checks++;
                if (s[0] !== e) begin errors++; $display("FAIL b2b_result[%0d] got %h exp %h", recv, s[0], e); end
                recv++;
            end
            if (iv[0] && !ir[0]) saw_low = 1'b1;
            if (iv[0] && ir[0]) sent++;
        end
        checks++;
        if (recv != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", recv); end
        checks++;
        if (saw_low !== 1'b1) begin errors++; $display("FAIL b2b_backpressure got in_ready_low=%b exp 1", saw_low); end
        @(negedge clk);
        put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
        #1;
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got out_valid=%b exp 0", ov[0]); end
    endtask

    task automatic test_bubbles;
        logic [9:0] hist = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            put(0, (c < 8) && (c % 2 == 0), 32'(c), 32'h1, 1'b0, OP_ADD, 1'b1);
            hist[c] = iv[0];
            #1;
            if (c >= 2) begin
                checks++;
                if (ov[0] !== hist[c-2]) begin
                    errors++; $display("FAIL bubble[%0d] got out_valid=%b exp %b", c, ov[0], hist[c-2]);
                end
            end
        end
    endtask

    task automatic test_reset_flight;
        @(negedge clk);
        put(0, 1'b1, 32'h0101, 32'h0202, 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        put(0, 1'b1, 32'h0303, 32'h0404, 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
        checks++;
        if (ov[0] !== 1'b1) begin errors++; $display("FAIL flight_before got out_valid=%b exp 1", ov[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov[0], s[0]} !== 33'h0) begin
            errors++; $display("FAIL flight_async got out_valid=%b S=%h exp 0 0", ov[0], s[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b0) begin errors++; $display("FAIL flight_ghost[%0d] got out_valid=%b exp 0", c, ov[0]); end
        end
        put(0, 1'b1, 32'h1234, 32'h4321, 1'b1, OP_ADD, 1'b1);
        @(negedge clk);
        put(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
        @(negedge clk);
        checks++;
        if ({ov[0], s[0][15:0], co[0], of[0], zr[0]} !== {1'b1, 16'h5556, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flight_after got v=%b S=%h c=%b o=%b z=%b exp v=1 S=5556 c=0 o=0 z=0",
                     ov[0], s[0][15:0], co[0], of[0], zr[0]);
        end
    endtask

    task automatic test_random(input int g, input int n);
        int          w = WS[g];
        logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        logic [34:0] q[$];
        logic [34:0] e, got;
        logic [32:0] full;
        logic [31:0] x, y, bb, sm;
        logic        c, cc, v, r;
        op_t         o;
        int          acc = 0;
        for (int cyc = 0; cyc < n * 8 + 100 && (acc < n || q.size() > 0); cyc++) begin
            @(negedge clk);
            x = $urandom & m;
            y = $urandom & m;
            c = 1'($urandom_range(0, 1));
            o = op_t'($urandom_range(0, 1));
            v = (acc < n) && ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3) != 0;
            put(g, v, x, y, c, o, r);
            #1;
            if (ov[g] && ordy[g]) begin
                got = {s[g] & m, co[g], of[g], zr[g]};
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL random%0d_extra got %h with nothing outstanding", g, got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL random%0d got %h exp %h", g, got, e); end
                end
            end
            if (iv[g] && ir[g]) begin
                bb   = (o == OP_SUB) ? (~y & m) : y;
                cc   = (o == OP_SUB) ? ~c : c;
                full = {1'b0, x} + {1'b0, bb} + {32'h0, cc};
                sm   = full[31:0] & m;
                q.push_back({sm, full[w], (x[w-1] == bb[w-1]) && (sm[w-1] != x[w-1]), sm == 32'h0});
                acc++;
            end
        end
        checks++;
        if (acc != n || q.size() != 0) begin
            errors++; $display("FAIL random%0d_drain got accepted=%0d pending=%0d exp %0d 0", g, acc, q.size(), n);
        end
        @(negedge clk);
        put(g, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_arith();
        test_back_to_back();
        test_bubbles();
        test_reset_flight();
        test_random(1, 400);
        test_random(2, 400);
        test_random(3, 400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
